// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_pkg
// Brief    : Shared rv32i definitions for the fetch stage (width, NOP word,
//            fetch FSM state encoding).
// Revision : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  // Native data/address width of the core.
  localparam int unsigned RV_XLEN = 32;

  // addi x0,x0,0 : the canonical RV32I no-op, used as the fault marker word.
  localparam logic [31:0] RV_NOP_INSN = 32'h0000_0013;

  // Fetch FSM states. DROP_HOLD presents a timed-out fault like HOLD while a
  // late response may still arrive and has to be swallowed.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT      = 3'd2,
    HOLD      = 3'd3,
    DROP      = 3'd4,
    DROP_HOLD = 3'd5
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage. Issues one request/grant/response
//            transaction per PC, holds the fetched word under valid/ready and
//            steps the PC register on accept or redirect. Handles wait states,
//            flushes, misaligned PCs and response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN        = RV_XLEN,
  parameter int unsigned     TIMEOUT_CYC = 255,
  parameter logic [XLEN-1:0] NOP_INSN    = XLEN'(RV_NOP_INSN)
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_en_o,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            fault_o
);

  localparam int unsigned   CW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT_CYC);

  fetch_state_e    r_state;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_fault;

  logic            w_aligned;
  logic            w_hold;
  logic            w_accept;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_timeout;

  assign w_aligned = (pc_i[1:0] == 2'b00);
  assign w_hold    = (r_state == HOLD) || (r_state == DROP_HOLD);
  assign w_accept  = w_hold && inst_ready_i;
  assign w_cnt_nxt = r_cnt + 1'b1;
  // Expires once TIMEOUT_CYC cycles have elapsed without a response.
  assign w_timeout = (w_cnt_nxt == C_TIMEOUT);

  // Request, address and PC enable depend on the live PC / flush inputs:
  // the PC register loads at the end of the accept/flush cycle and the very
  // next REQ cycle must already present the new PC, so these cannot be
  // registered without losing a cycle per instruction.
  assign imem_req_o   = (r_state == REQ) && w_aligned;
  assign imem_addr_o  = (r_state == REQ) ? {pc_i[XLEN-1:2], 2'b00} : '0;
  assign pc_en_o      = (flush_i && (r_state != IDLE)) || w_accept;
  assign inst_valid_o = w_hold;
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_inst_pc;
  assign fault_o      = r_fault;

  // Fetch FSM, wait/timeout counter and instruction holding register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_inst    <= NOP_INSN;
      r_inst_pc <= '0;
      r_fault   <= 1'b0;
    end else begin
      // Counter restarts on every state change; only staying in WAIT/DROP
      // lets it advance.
      r_cnt <= '0;
      case (r_state)
        IDLE: r_state <= REQ;

        REQ: begin
          r_inst_pc <= pc_i;
          if (flush_i) begin
            // A grant seen together with the flush still owes a response.
            r_state <= (w_aligned && imem_gnt_i) ? DROP : REQ;
          end else if (!w_aligned) begin
            r_state <= HOLD;
            r_fault <= 1'b1;
            r_inst  <= NOP_INSN;
          end else if (imem_gnt_i) begin
            r_state <= WAIT;
          end
        end

        WAIT: begin
          if (flush_i) begin
            r_state <= imem_rvalid_i ? REQ : DROP;
          end else if (imem_rvalid_i) begin
            r_state <= HOLD;
            r_inst  <= imem_rdata_i;
            r_fault <= 1'b0;
          end else if (w_timeout) begin
            r_state <= DROP_HOLD;
            r_inst  <= NOP_INSN;
            r_fault <= 1'b1;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end

        HOLD: begin
          if (flush_i || inst_ready_i) begin
            r_state <= REQ;
            r_fault <= 1'b0;
          end
        end

        DROP_HOLD: begin
          // Leaving before the late response shows up must still wait it
          // out, otherwise it would be taken as the next fetch's data.
          if (flush_i || inst_ready_i) begin
            r_state <= imem_rvalid_i ? REQ : DROP;
            r_fault <= 1'b0;
          end else if (imem_rvalid_i) begin
            r_state <= HOLD;
          end
        end

        DROP: begin
          if (imem_rvalid_i || w_timeout) begin
            r_state <= REQ;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit (TIMEOUT_CYC = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        pc_en_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        fault_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit #(
    .XLEN        (32),
    .TIMEOUT_CYC (4),
    .NOP_INSN    (NOP)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .pc_i          (pc_i),
    .pc_en_o       (pc_en_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .fault_o       (fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pc_en"}, 32'(pc_en_o), 32'd0);
    check_eq({tag, "_req"},   32'(imem_req_o), 32'd0);
    check_eq({tag, "_addr"},  imem_addr_o, 32'd0);
    check_eq({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
    check_eq({tag, "_inst"},  inst_o, NOP);
    check_eq({tag, "_ipc"},   inst_pc_o, 32'd0);
    check_eq({tag, "_fault"}, 32'(fault_o), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    pc_i          = 32'h0;
    flush_i       = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    inst_ready_i  = 1'b0;

    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    settle();
    check_eq("idle_req", 32'(imem_req_o), 32'd0);
    step();                                   // -> REQ

    // ---------------- zero-wait fetch ----------------
    imem_gnt_i = 1'b1;
    settle();
    check_eq("zw_req",  32'(imem_req_o), 32'd1);
    check_eq("zw_addr", imem_addr_o, 32'h0);
    step();                                   // -> WAIT
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0050_0093;
    settle();
    check_eq("zw_valid_early", 32'(inst_valid_o), 32'd0);
    step();                                   // -> HOLD (2 cycles after REQ)
    imem_rvalid_i = 1'b0;
    settle();
    check_eq("zw_valid", 32'(inst_valid_o), 32'd1);
    check_eq("zw_inst",  inst_o, 32'h0050_0093);
    check_eq("zw_ipc",   inst_pc_o, 32'h0);
    check_eq("zw_fault", 32'(fault_o), 32'd0);
    check_eq("zw_pcen_hold", 32'(pc_en_o), 32'd0);
    inst_ready_i = 1'b1;
    settle();
    check_eq("zw_pcen_acc", 32'(pc_en_o), 32'd1);
    step();                                   // -> REQ
    inst_ready_i = 1'b0;
    pc_i         = 32'h4;
    settle();
    check_eq("zw_pcen_once", 32'(pc_en_o), 32'd0);
    check_eq("zw_valid_off", 32'(inst_valid_o), 32'd0);

    // ---------------- backpressure / wait states ----------------
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_req_wait",  32'(imem_req_o), 32'd1);
      check_eq("bp_addr_wait", imem_addr_o, 32'h4);
      check_eq("bp_pcen_gnt",  32'(pc_en_o), 32'd0);
      step();
      settle();
    end
    imem_gnt_i = 1'b1;
    settle();
    check_eq("bp_addr_gnt", imem_addr_o, 32'h4);
    step();                                   // -> WAIT
    imem_gnt_i = 1'b0;
    settle();
    check_eq("bp_req_in_wait", 32'(imem_req_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      check_eq("bp_valid_wait", 32'(inst_valid_o), 32'd0);
      check_eq("bp_pcen_wait",  32'(pc_en_o), 32'd0);
      step();
      settle();
    end
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h00A0_0113;
    step();                                   // -> HOLD
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'hFFFF_FFFF;
    settle();
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_valid_held", 32'(inst_valid_o), 32'd1);
      check_eq("bp_inst_held",  inst_o, 32'h00A0_0113);
      check_eq("bp_ipc_held",   inst_pc_o, 32'h4);
      check_eq("bp_pcen_held",  32'(pc_en_o), 32'd0);
      step();
      settle();
    end
    inst_ready_i = 1'b1;
    settle();
    check_eq("bp_pcen_acc", 32'(pc_en_o), 32'd1);
    step();                                   // -> REQ
    inst_ready_i = 1'b0;
    pc_i         = 32'h10;

    // ---------------- flush in WAIT ----------------
    imem_gnt_i = 1'b1;
    step();                                   // -> WAIT
    imem_gnt_i = 1'b0;
    flush_i    = 1'b1;
    settle();
    check_eq("fw_pcen_flush", 32'(pc_en_o), 32'd1);
    step();                                   // -> DROP
    flush_i = 1'b0;
    pc_i    = 32'h20;
    settle();
    check_eq("fw_pcen_drop", 32'(pc_en_o), 32'd0);
    check_eq("fw_req_drop",  32'(imem_req_o), 32'd0);
    step();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    settle();
    check_eq("fw_valid_drop", 32'(inst_valid_o), 32'd0);
    check_eq("fw_req_drop2",  32'(imem_req_o), 32'd0);
    step();                                   // -> REQ
    imem_rvalid_i = 1'b0;
    settle();
    check_eq("fw_req_new",  32'(imem_req_o), 32'd1);
    check_eq("fw_addr_new", imem_addr_o, 32'h20);
    check_eq("fw_valid",    32'(inst_valid_o), 32'd0);
    check_eq("fw_pcen",     32'(pc_en_o), 32'd0);

    // ---------------- flush coinciding with gnt ----------------
    imem_gnt_i = 1'b1;
    flush_i    = 1'b1;
    settle();
    check_eq("fg_pcen", 32'(pc_en_o), 32'd1);
    step();                                   // -> DROP
    imem_gnt_i = 1'b0;
    flush_i    = 1'b0;
    pc_i       = 32'h30;
    settle();
    check_eq("fg_req_drop", 32'(imem_req_o), 32'd0);
    step();
    settle();
    check_eq("fg_req_drop2", 32'(imem_req_o), 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h1111_1111;
    step();                                   // -> REQ
    imem_rvalid_i = 1'b0;
    settle();
    check_eq("fg_req_new",  32'(imem_req_o), 32'd1);
    check_eq("fg_addr_new", imem_addr_o, 32'h30);
    check_eq("fg_valid",    32'(inst_valid_o), 32'd0);

    // ---------------- flush coinciding with rvalid ----------------
    imem_gnt_i = 1'b1;
    step();                                   // -> WAIT
    imem_gnt_i    = 1'b0;
    flush_i       = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h2222_2222;
    settle();
    check_eq("fr_pcen", 32'(pc_en_o), 32'd1);
    step();                                   // -> REQ directly
    flush_i       = 1'b0;
    imem_rvalid_i = 1'b0;
    pc_i          = 32'h40;
    settle();
    check_eq("fr_req_direct", 32'(imem_req_o), 32'd1);
    check_eq("fr_addr",       imem_addr_o, 32'h40);
    check_eq("fr_valid",      32'(inst_valid_o), 32'd0);
    imem_gnt_i = 1'b1;
    step();                                   // -> WAIT
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h3333_3333;
    step();                                   // -> HOLD
    imem_rvalid_i = 1'b0;
    settle();
    check_eq("fr_valid_next", 32'(inst_valid_o), 32'd1);
    check_eq("fr_inst_next",  inst_o, 32'h3333_3333);
    check_eq("fr_ipc_next",   inst_pc_o, 32'h40);
    inst_ready_i = 1'b1;
    step();                                   // -> REQ
    inst_ready_i = 1'b0;

    // ---------------- misaligned PC ----------------
    pc_i = 32'h6;
    settle();
    check_eq("ma_req",  32'(imem_req_o), 32'd0);
    check_eq("ma_pcen", 32'(pc_en_o), 32'd0);
    step();                                   // -> HOLD (fault)
    settle();
    check_eq("ma_valid", 32'(inst_valid_o), 32'd1);
    check_eq("ma_fault", 32'(fault_o), 32'd1);
    check_eq("ma_inst",  inst_o, NOP);
    check_eq("ma_ipc",   inst_pc_o, 32'h6);
    check_eq("ma_req2",  32'(imem_req_o), 32'd0);
    inst_ready_i = 1'b1;
    settle();
    check_eq("ma_pcen_acc", 32'(pc_en_o), 32'd1);
    step();                                   // -> REQ
    inst_ready_i = 1'b0;
    pc_i         = 32'h50;
    settle();
    check_eq("ma_fault_clr", 32'(fault_o), 32'd0);

    // ---------------- timeout, late rvalid, async reset ----------------
    imem_gnt_i = 1'b1;
    step();                                   // -> WAIT
    imem_gnt_i = 1'b0;
    settle();
    for (int i = 0; i < 4; i++) begin
      check_eq("to_valid_wait", 32'(inst_valid_o), 32'd0);
      check_eq("to_fault_wait", 32'(fault_o), 32'd0);
      step();
      settle();
    end
    check_eq("to_valid", 32'(inst_valid_o), 32'd1);
    check_eq("to_fault", 32'(fault_o), 32'd1);
    check_eq("to_inst",  inst_o, NOP);
    check_eq("to_ipc",   inst_pc_o, 32'h50);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h4444_4444;
    step();                                   // late response swallowed
    imem_rvalid_i = 1'b0;
    settle();
    check_eq("late_valid", 32'(inst_valid_o), 32'd1);
    check_eq("late_inst",  inst_o, NOP);
    check_eq("late_fault", 32'(fault_o), 32'd1);
    check_eq("late_pcen",  32'(pc_en_o), 32'd0);
    inst_ready_i = 1'b1;
    step();                                   // -> REQ
    inst_ready_i = 1'b0;
    pc_i         = 32'h54;
    settle();
    check_eq("late_req_new", 32'(imem_req_o), 32'd1);
    check_eq("late_addr",    imem_addr_o, 32'h54);
    imem_gnt_i = 1'b1;
    step();                                   // -> WAIT
    imem_gnt_i = 1'b0;
    step();                                   // mid-WAIT
    rst_n = 1'b0;
    settle();
    check_reset_outputs("arst");
    step();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
